// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access controller.
//
// It takes the EX/MEM load/store controls and runs a request/ready handshake
// with a variable-latency data memory. It stalls the pipeline while an access
// is outstanding, and it presents the registered load result on mem_mo for
// MEM/WB to capture in DONE. A timeout counter bounds every access.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap accesses whose byte
// address is not word aligned. Such an access goes IDLE->DONE with mem_err=1
// and issues no request. Without the macro, address bits [1:0] are ignored.
module mem_access_stage #(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       mem_Alu_Result,
  input  logic [31:0]       mem_di,
  input  logic              mem_m2reg,
  input  logic              mem_wmem,
  output logic              mem_stall,
  output logic [31:0]       mem_mo,
  output logic              mem_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic [31:0]       dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // The counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             access;
  logic             misaligned;
  logic             timeout_hit;

  // Low address bits matter only when the misalignment trap is built in.
  wire unused_addr_lsbs = ^mem_Alu_Result[1:0];

  // Request decode, misalignment detect and timeout detect.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    access      = mem_m2reg | mem_wmem;
    misaligned  = 1'b0;
    timeout_hit = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned  = (mem_Alu_Result[1:0] != 2'b00);
`endif
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = (wait_cnt == CNT_LAST);
    end
  end

  // Freeze upstream stages while an access is detected or outstanding.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      S_IDLE:  mem_stall = access;
      S_WAIT:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Handshake FSM with registered memory-side and pipeline-side outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (!clrn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      mem_mo   <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && misaligned) begin
            // Trap: no request reaches memory, and the error reports in DONE.
            mem_mo  <= '0;
            mem_err <= 1'b1;
            state   <= S_DONE;
          end else if (access) begin
            // A simultaneous load and store is treated as a store.
            dm_addr  <= mem_Alu_Result[ADDR_W+1:2];
            dm_wdata <= mem_di;
            dm_we    <= mem_wmem;
            dm_req   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Completion wins over a timeout that falls in the same cycle.
          if (dm_ready) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            mem_mo <= dm_we ? 32'h0 : dm_rdata;
            state  <= S_DONE;
          end else if (timeout_hit) begin
            dm_req  <= 1'b0;
            dm_we   <= 1'b0;
            mem_mo  <= '0;
            mem_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // MEM/WB captures mem_mo on this edge. The next instruction is
          // evaluated in IDLE.
          mem_err <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven directed checks for mem_access_stage,
// plus hand-written sequences for misalignment, timeout and mid-access reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] mem_Alu_Result;
  logic [31:0] mem_di;
  logic        mem_m2reg;
  logic        mem_wmem;
  logic        mem_stall;
  logic [31:0] mem_mo;
  logic        mem_err;
  logic        dm_req;
  logic        dm_we;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(30), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .mem_Alu_Result (mem_Alu_Result),
    .mem_di         (mem_di),
    .mem_m2reg      (mem_m2reg),
    .mem_wmem       (mem_wmem),
    .mem_stall      (mem_stall),
    .mem_mo         (mem_mo),
    .mem_err        (mem_err),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_ready       (dm_ready),
    .dm_rdata       (dm_rdata)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] di;
    logic        m2;
    logic        wm;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [29:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_mo;
    logic        e_err;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs after the falling edge and let them settle.
  task automatic drive(input logic rn, input logic [31:0] a, input logic [31:0] d,
                       input logic m, input logic w, input logic r,
                       input logic [31:0] rd);
    @(negedge clk);
    clrn = rn; mem_Alu_Result = a; mem_di = d;
    mem_m2reg = m; mem_wmem = w; dm_ready = r; dm_rdata = rd;
    #1;
  endtask

  initial begin
    int stall_cycles;
    int req_cycles;

    //          alu           di            m2    wm    rdy   rdata          stall req   we    addr           wdata         mo            err
    vecs[0]  = '{32'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h0,         32'h0,        32'h0,        1'b0};
    vecs[1]  = '{32'h10,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 30'h0,         32'h0,        32'h0,        1'b0};
    vecs[2]  = '{32'h10,      32'h0,        1'b1, 1'b0, 1'b1, 32'hCAFEF00D,  1'b1, 1'b1, 1'b0, 30'h4,         32'h0,        32'h0,        1'b0};
    vecs[3]  = '{32'h10,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h4,         32'h0,        32'hCAFEF00D, 1'b0};
    vecs[4]  = '{32'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h4,         32'h0,        32'hCAFEF00D, 1'b0};
    vecs[5]  = '{32'h100,     32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 30'h4,         32'h0,        32'hCAFEF00D, 1'b0};
    vecs[6]  = '{32'h100,     32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 30'h40,        32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{32'h100,     32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 30'h40,        32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{32'h100,     32'h12345678, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF,  1'b1, 1'b1, 1'b1, 30'h40,        32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{32'h100,     32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h40,        32'h12345678, 32'h0,        1'b0};
    vecs[10] = '{32'h20,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 30'h40,        32'h12345678, 32'h0,        1'b0};
    vecs[11] = '{32'h20,      32'h0,        1'b1, 1'b0, 1'b1, 32'hA5A50001,  1'b1, 1'b1, 1'b0, 30'h8,         32'h0,        32'h0,        1'b0};
    vecs[12] = '{32'h20,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h8,         32'h0,        32'hA5A50001, 1'b0};
    vecs[13] = '{32'hFFFFFFFC,32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 30'h8,         32'h0,        32'hA5A50001, 1'b0};
    vecs[14] = '{32'hFFFFFFFC,32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'h77777777,  1'b1, 1'b1, 1'b1, 30'h3FFFFFFF,  32'hDEADBEEF, 32'hA5A50001, 1'b0};
    vecs[15] = '{32'hFFFFFFFC,32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h3FFFFFFF,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[16] = '{32'h0,       32'h0,        1'b0, 1'b0, 1'b1, 32'h12121212,  1'b0, 1'b0, 1'b0, 30'h3FFFFFFF,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[17] = '{32'h80,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 30'h3FFFFFFF,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[18] = '{32'h80,      32'h0,        1'b1, 1'b0, 1'b1, 32'h13579BDF,  1'b1, 1'b1, 1'b0, 30'h20,        32'h0,        32'h0,        1'b0};
    vecs[19] = '{32'h80,      32'h0,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h20,        32'h0,        32'h13579BDF, 1'b0};
    vecs[20] = '{32'h0,       32'h0,        1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 30'h20,        32'h0,        32'h13579BDF, 1'b0};

    clrn = 1'b0; mem_Alu_Result = '0; mem_di = '0;
    mem_m2reg = 1'b0; mem_wmem = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    repeat (2) @(posedge clk);

    // Table: one row per cycle. Row 0 observes the reset values.
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, vecs[i].alu, vecs[i].di, vecs[i].m2, vecs[i].wm, vecs[i].rdy, vecs[i].rdata);
      check($sformatf("row%0d stall", i), {31'h0, mem_stall}, {31'h0, vecs[i].e_stall});
      check($sformatf("row%0d req",   i), {31'h0, dm_req},    {31'h0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        check($sformatf("row%0d we",    i), {31'h0, dm_we},     {31'h0, vecs[i].e_we});
        check($sformatf("row%0d wdata", i), dm_wdata,           vecs[i].e_wdata);
      end
      check($sformatf("row%0d addr",  i), {2'b00, dm_addr},   {2'b00, vecs[i].e_addr});
      check($sformatf("row%0d mo",    i), mem_mo,             vecs[i].e_mo);
      check($sformatf("row%0d err",   i), {31'h0, mem_err},   {31'h0, vecs[i].e_err});
    end

    // Misaligned load at byte address 0x3.
    drive(1'b1, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("mis idle stall", {31'h0, mem_stall}, 32'h1);
    check("mis idle req",   {31'h0, dm_req},    32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("mis done stall", {31'h0, mem_stall}, 32'h0);
    check("mis done req",   {31'h0, dm_req},    32'h0);
    check("mis done err",   {31'h0, mem_err},   32'h1);
    check("mis done mo",    mem_mo,             32'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mis exit err",   {31'h0, mem_err},   32'h0);
`else
    drive(1'b1, 32'h3, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    check("mis wait req",   {31'h0, dm_req},    32'h1);
    check("mis wait addr",  {2'b00, dm_addr},   32'h0);
    drive(1'b1, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("mis done stall", {31'h0, mem_stall}, 32'h0);
    check("mis done err",   {31'h0, mem_err},   32'h0);
    check("mis done mo",    mem_mo,             32'h0BADF00D);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
`endif

    // Timeout: a load that is never acknowledged.
    stall_cycles = 0;
    req_cycles   = 0;
    drive(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (!mem_stall) break;
      stall_cycles++;
      if (dm_req) req_cycles++;
      drive(1'b1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("tmo stall cycles", stall_cycles, 32'd17);
    check("tmo wait cycles",  req_cycles,   32'd16);
    check("tmo done err",     {31'h0, mem_err}, 32'h1);
    check("tmo done mo",      mem_mo,           32'h0);
    check("tmo done req",     {31'h0, dm_req},  32'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("tmo exit err",     {31'h0, mem_err}, 32'h0);

    // Load a nonzero value, then reset in the middle of the next load.
    drive(1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 32'h600DF00D);
    drive(1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("pre-rst mo",       mem_mo, 32'h600DF00D);
    drive(1'b1, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("pre-rst wait req", {31'h0, dm_req}, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst req",          {31'h0, dm_req},    32'h0);
    check("rst mo",           mem_mo,             32'h0);
    check("rst addr",         {2'b00, dm_addr},   32'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst stall",        {31'h0, mem_stall}, 32'h0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("post-rst rdy req", {31'h0, dm_req},    32'h0);
    check("post-rst rdy mo",  mem_mo,             32'h0);
    check("post-rst stall",   {31'h0, mem_stall}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access controller, directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM outputs (ALU result as address, store data, load/store controls) and runs a variable-latency request/ready handshake to the data memory.
- Stalls the pipeline while an access is outstanding. Presents the registered load result on mem_mo for the MEM/WB register to capture.
- Bounds every access with a timeout counter.

Parameters:
- ADDR_W, 30, word-address width driven on dm_addr; dm_addr = mem_Alu_Result[ADDR_W+1:2].
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before an access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on posedge.
- clrn  input  1  reset, synchronous, active-low.
- mem_Alu_Result  input  32  byte address from EX/MEM.
- mem_di  input  32  store data.
- mem_m2reg  input  1  load request.
- mem_wmem  input  1  store request.
- mem_stall  output  1  freeze PC/IF/ID/EX/MEM registers; combinational.
- mem_mo  output  32  registered load data to MEM/WB.
- mem_err  output  1  one-cycle error flag; high in DONE on timeout or misalignment.
- dm_req  output  1  memory request, registered.
- dm_we  output  1  write enable, valid while dm_req=1.
- dm_addr  output  ADDR_W  word address, registered.
- dm_wdata  output  32  write data, registered.
- dm_ready  input  1  memory completion; meaningful only in WAIT.
- dm_rdata  input  32  read data, valid with dm_ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, clrn).
- Reset: on the clk edge with clrn=0, go to IDLE.
  - Reset values: dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, mem_mo=0, mem_err=0, timeout counter=0.
  - A reset mid-access abandons the transaction; dm_req is low after that edge and any later dm_ready is ignored.
- access = mem_m2reg | mem_wmem. If both are high, treat as a store; mem_mo is then loaded with 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access=0: stay in IDLE.
  - access=1: latch dm_addr, dm_wdata and dm_we=mem_wmem; set dm_req=1; clear the counter; go to WAIT.
- WAIT:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable.
  - dm_ready=1: dm_req<=0; mem_mo<=dm_rdata for a load, or mem_mo<=0 for a store; go to DONE.
  - dm_ready=0 with TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort. dm_req<=0, mem_mo<=0, mem_err<=1, go to DONE.
  - Otherwise: counter+1, stay in WAIT.
  - dm_ready takes priority over timeout when both occur on the same cycle.
- DONE:
  - mem_stall=0, so the pipeline advances and MEM/WB captures mem_mo on this edge.
  - Next state is always IDLE; mem_err<=0 on exit.
  - The following instruction is evaluated in IDLE on the next cycle; there is no back-to-back issue from DONE.
- mem_stall = (IDLE & access) | WAIT. It is 0 in DONE and in IDLE with no access.
- Latency: an access costs at least 3 cycles (IDLE detect, 1 WAIT, DONE), plus one extra cycle per additional WAIT cycle.
- Non-memory instructions pass with zero stall; mem_mo holds its last value.
- dm_ready outside WAIT is ignored.
- Address bits above ADDR_W+1 are dropped.
- mem_mo changes only on WAIT->DONE and on reset.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: when IDLE sees access=1 with mem_Alu_Result[1:0]!=0, no request is issued.
  - FSM goes IDLE->DONE directly with mem_err=1 and mem_mo=0.
  - The stall lasts 1 cycle.
- Undefined: mem_Alu_Result[1:0] are ignored and the access proceeds word-aligned as normal.

Test Plan:
- Reset: clrn=0 for 2 cycles during WAIT -> dm_req=0, mem_mo=0, mem_stall=0, state IDLE; a dm_ready pulse one cycle later has no effect.
- Load, zero wait: mem_m2reg=1, addr=0x0000_0010, dm_ready in the first WAIT cycle with dm_rdata=0xCAFE_F00D -> dm_addr=0x4; mem_stall high for exactly 2 cycles; mem_mo=0xCAFE_F00D in DONE; mem_err=0.
- Store, 3-cycle wait: mem_wmem=1, addr=0x100, mem_di=0x1234_5678, dm_ready on the 3rd WAIT cycle -> dm_we=1, dm_addr=0x40, dm_wdata=0x1234_5678 held for 3 cycles; mem_stall high for 4 cycles; mem_mo=0.
- Timeout: load with dm_ready never asserted, TIMEOUT_CYCLES=16 -> exactly 16 WAIT cycles, then DONE with mem_err=1 for 1 cycle and mem_mo=0; mem_stall high for 17 cycles total.
- Back-to-back: load followed by store, each acknowledged on the first WAIT cycle -> sequence IDLE,WAIT,DONE,IDLE,WAIT,DONE; mem_stall pattern 1,1,0,1,1,0.
- MEM_MISALIGN_TRAP_EN defined, load at addr=0x0000_0003 -> dm_req stays 0; mem_stall=1 for 1 cycle; DONE with mem_err=1; mem_mo=0.
